// File: rtl/cci_mem_rsp_model_if.sv
// CCI request/response bundle between the AFU-side driver and the memory response model.
`ifndef CCI_TX_HDR_WIDTH
`define CCI_TX_HDR_WIDTH 61
`endif
`ifndef ASE_CCI_RX_HDR_WIDTH
`define ASE_CCI_RX_HDR_WIDTH 18
`endif
`ifndef CCI_DATA_WIDTH
`define CCI_DATA_WIDTH 512
`endif

interface cci_mem_rsp_model_if;
    logic                             lp_initdone;
    logic [`CCI_TX_HDR_WIDTH-1:0]     tx_c0_header;
    logic                             tx_c0_rdvalid;
    logic [`CCI_TX_HDR_WIDTH-1:0]     tx_c1_header;
    logic [`CCI_DATA_WIDTH-1:0]       tx_c1_data;
    logic                             tx_c1_wrvalid;
    logic                             tx_c0_almostfull;
    logic                             tx_c1_almostfull;
    logic [`ASE_CCI_RX_HDR_WIDTH-1:0] rx_c0_header;
    logic [`CCI_DATA_WIDTH-1:0]       rx_c0_data;
    logic                             rx_c0_rdvalid;
    logic [`ASE_CCI_RX_HDR_WIDTH-1:0] rx_c1_header;
    logic                             rx_c1_wrvalid;
    logic                             ovf_err;
    logic                             type_err;

    modport master (
        output lp_initdone, tx_c0_header, tx_c0_rdvalid, tx_c1_header, tx_c1_data, tx_c1_wrvalid,
        input  tx_c0_almostfull, tx_c1_almostfull, rx_c0_header, rx_c0_data, rx_c0_rdvalid,
               rx_c1_header, rx_c1_wrvalid, ovf_err, type_err
    );

    modport slave (
        input  lp_initdone, tx_c0_header, tx_c0_rdvalid, tx_c1_header, tx_c1_data, tx_c1_wrvalid,
        output tx_c0_almostfull, tx_c1_almostfull, rx_c0_header, rx_c0_data, rx_c0_rdvalid,
               rx_c1_header, rx_c1_wrvalid, ovf_err, type_err
    );
endinterface

// File: rtl/cci_mem_rsp_model.sv
// Fixed-latency CCI read/write responder backed by a small cache-line memory.
// Per-channel in-flight FIFOs retire their head once it has aged LATENCY-1 cycles.
`ifndef CCI_TX_HDR_WIDTH
`define CCI_TX_HDR_WIDTH 61
`endif
`ifndef ASE_CCI_RX_HDR_WIDTH
`define ASE_CCI_RX_HDR_WIDTH 18
`endif
`ifndef CCI_DATA_WIDTH
`define CCI_DATA_WIDTH 512
`endif
`ifndef TX_META_TYPERANGE
`define TX_META_TYPERANGE 55:52
`endif
`ifndef RX_MDATA_BITRANGE
`define RX_MDATA_BITRANGE 13:0
`endif
`ifndef ASE_TX0_RDLINE
`define ASE_TX0_RDLINE   4'h4
`define ASE_TX0_RDLINE_S 4'h8
`define ASE_TX0_RDLINE_I 4'h6
`define ASE_TX0_RDLINE_O 4'h7
`define ASE_TX1_WRTHRU   4'h1
`define ASE_TX1_WRLINE   4'h2
`define ASE_TX1_WRFENCE  4'h5
`endif

module cci_mem_rsp_model #(
    parameter int LATENCY     = 8,
    parameter int DEPTH       = 16,
    parameter int AFULL_SLACK = 4,
    parameter int MEM_LINES   = 64
) (
    input  logic               clk,
    input  logic               sys_reset,
    cci_mem_rsp_model_if.slave cci
);
    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int IDX_W    = $clog2(MEM_LINES);
    localparam int ADDR_LSB = 14;
    localparam int DW       = `CCI_DATA_WIDTH;
    localparam int RHW      = `ASE_CCI_RX_HDR_WIDTH;

    logic [15:0]         now_reg;
    logic [3:0]          c0_type, c1_type;
    logic [1:0]          req, known, retire, enq, drop, afull;
    logic [1:0][13:0]    req_mdata, head_mdata;
    logic [IDX_W-1:0]    c0_idx, c1_idx;
    logic                c1_is_write, mem_we;
    logic [PTR_W-1:0]    c0_wr_ptr, c0_rd_ptr;
    logic [RHW-1:0]      c0_rsp_hdr, c1_rsp_hdr;
    logic [DW-1:0]       line_mem [MEM_LINES];
    logic [DW-1:0]       rdata_mem [DEPTH];
    logic                unused_hdr_bits;

    assign c0_type      = cci.tx_c0_header[`TX_META_TYPERANGE];
    assign c1_type      = cci.tx_c1_header[`TX_META_TYPERANGE];
    assign known[0]     = c0_type inside {`ASE_TX0_RDLINE, `ASE_TX0_RDLINE_S,
                                          `ASE_TX0_RDLINE_I, `ASE_TX0_RDLINE_O};
    assign known[1]     = c1_type inside {`ASE_TX1_WRLINE, `ASE_TX1_WRTHRU, `ASE_TX1_WRFENCE};
    assign c1_is_write  = c1_type inside {`ASE_TX1_WRLINE, `ASE_TX1_WRTHRU};
    assign req[0]       = cci.lp_initdone & cci.tx_c0_rdvalid & ~sys_reset;
    assign req[1]       = cci.lp_initdone & cci.tx_c1_wrvalid & ~sys_reset;
    assign req_mdata[0] = cci.tx_c0_header[13:0];
    assign req_mdata[1] = cci.tx_c1_header[13:0];
    assign c0_idx       = cci.tx_c0_header[ADDR_LSB +: IDX_W];
    assign c1_idx       = cci.tx_c1_header[ADDR_LSB +: IDX_W];
    assign unused_hdr_bits = ^{cci.tx_c0_header, cci.tx_c1_header};

    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
        logic [15:0]      stamp_mem [DEPTH];
        logic [13:0]      mdata_mem [DEPTH];
        logic [CNT_W-1:0] cnt_reg, cnt_next;
        logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
        logic [15:0]      age;
        logic             retire_w, enq_w, afull_reg;

        // Age wraps modulo 2^16 along with the free-running counter.
        assign age      = now_reg - stamp_mem[rd_ptr_reg];
        assign retire_w = (cnt_reg != '0) && (age == 16'(LATENCY - 1));
        assign enq_w    = req[gi] && known[gi] && ((cnt_reg != CNT_W'(DEPTH)) || retire_w);
        assign cnt_next = cnt_reg + CNT_W'(enq_w) - CNT_W'(retire_w);

        assign retire[gi]     = retire_w;
        assign enq[gi]        = enq_w;
        assign drop[gi]       = req[gi] && known[gi] && !enq_w;
        assign afull[gi]      = afull_reg;
        assign head_mdata[gi] = mdata_mem[rd_ptr_reg];

        always_ff @(posedge clk or posedge sys_reset) begin
            if (sys_reset) begin
                cnt_reg    <= '0;
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                afull_reg  <= 1'b0;
            end else begin
                cnt_reg   <= cnt_next;
                afull_reg <= cnt_next >= CNT_W'(DEPTH - AFULL_SLACK);
                if (enq_w)    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                if (retire_w) rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (enq_w) begin
                stamp_mem[wr_ptr_reg] <= now_reg;
                mdata_mem[wr_ptr_reg] <= req_mdata[gi];
            end
        end

        if (gi == 0) begin : g_c0_ptr
            assign c0_wr_ptr = wr_ptr_reg;
            assign c0_rd_ptr = rd_ptr_reg;
        end
    end

    // Read data is captured from the pre-write memory contents, so a same-cycle
    // write to the same line is not visible to the read.
    assign mem_we = enq[1] & c1_is_write;

    always_ff @(posedge clk) begin
        if (mem_we) line_mem[c1_idx] <= cci.tx_c1_data;
    end

    always_ff @(posedge clk) begin
        if (enq[0]) rdata_mem[c0_wr_ptr] <= line_mem[c0_idx];
    end

    always_comb begin
        c0_rsp_hdr = '0;
        c1_rsp_hdr = '0;
        c0_rsp_hdr[`RX_MDATA_BITRANGE] = head_mdata[0];
        c1_rsp_hdr[`RX_MDATA_BITRANGE] = head_mdata[1];
    end

    assign cci.tx_c0_almostfull = afull[0];
    assign cci.tx_c1_almostfull = afull[1];

    always_ff @(posedge clk or posedge sys_reset) begin
        if (sys_reset) begin
            now_reg           <= '0;
            cci.rx_c0_rdvalid <= 1'b0;
            cci.rx_c0_header  <= '0;
            cci.rx_c0_data    <= '0;
            cci.rx_c1_wrvalid <= 1'b0;
            cci.rx_c1_header  <= '0;
            cci.ovf_err       <= 1'b0;
            cci.type_err      <= 1'b0;
        end else begin
            now_reg           <= now_reg + 16'd1;
            cci.rx_c0_rdvalid <= retire[0];
            cci.rx_c1_wrvalid <= retire[1];
            if (retire[0]) begin
                cci.rx_c0_header <= c0_rsp_hdr;
                cci.rx_c0_data   <= rdata_mem[c0_rd_ptr];
            end
            if (retire[1]) cci.rx_c1_header <= c1_rsp_hdr;
            if (|drop)            cci.ovf_err  <= 1'b1;
            if (|(req & ~known))  cci.type_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_cci_mem_rsp_model.sv
// Randomized bench for cci_mem_rsp_model against a queue-based latency/occupancy model.
`ifndef CCI_TX_HDR_WIDTH
`define CCI_TX_HDR_WIDTH 61
`endif
`ifndef ASE_CCI_RX_HDR_WIDTH
`define ASE_CCI_RX_HDR_WIDTH 18
`endif
`ifndef CCI_DATA_WIDTH
`define CCI_DATA_WIDTH 512
`endif
`ifndef TX_META_TYPERANGE
`define TX_META_TYPERANGE 55:52
`endif
`ifndef RX_MDATA_BITRANGE
`define RX_MDATA_BITRANGE 13:0
`endif
`ifndef ASE_TX0_RDLINE
`define ASE_TX0_RDLINE   4'h4
`define ASE_TX0_RDLINE_S 4'h8
`define ASE_TX0_RDLINE_I 4'h6
`define ASE_TX0_RDLINE_O 4'h7
`define ASE_TX1_WRTHRU   4'h1
`define ASE_TX1_WRLINE   4'h2
`define ASE_TX1_WRFENCE  4'h5
`endif

module tb_cci_mem_rsp_model;
    localparam int LAT   = 32;
    localparam int DEP   = 16;
    localparam int SLACK = 4;
    localparam int LINES = 64;
    localparam int IW    = $clog2(LINES);
    localparam int RXW   = `ASE_CCI_RX_HDR_WIDTH;

    typedef struct {
        int           due;
        logic [13:0]  mdata;
        logic [511:0] data;
    } rsp_t;

    logic clk = 1'b0;
    logic sys_reset = 1'b1;
    always #5 clk = ~clk;

    cci_mem_rsp_model_if bus ();

    cci_mem_rsp_model #(
        .LATENCY(LAT), .DEPTH(DEP), .AFULL_SLACK(SLACK), .MEM_LINES(LINES)
    ) dut (
        .clk(clk),
        .sys_reset(sys_reset),
        .cci(bus)
    );

    rsp_t         q0[$], q1[$];
    int           acc0[$], acc1[$];
    logic [511:0] mem_m [LINES];
    bit           ovf_m, type_m;
    int           t, errors, checks;
    logic [511:0] pat, rdat;
    logic [3:0]   rty0, rty1;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
        end
    endtask

    function automatic int in_flight(input int acc[$], input int lo, input int hi);
        int n = 0;
        foreach (acc[i]) if (acc[i] >= lo && acc[i] <= hi) n++;
        return n;
    endfunction

    function automatic logic [`CCI_TX_HDR_WIDTH-1:0] mkhdr(input logic [3:0] ty,
                                                           input logic [31:0] a, input logic [13:0] m);
        logic [`CCI_TX_HDR_WIDTH-1:0] h = '0;
        h[`TX_META_TYPERANGE] = ty;
        h[45:14] = a;
        h[13:0]  = m;
        return h;
    endfunction

    function automatic logic [511:0] rand_line();
        logic [511:0] d;
        for (int k = 0; k < 16; k++) d[32*k +: 32] = $urandom();
        return d;
    endfunction

    task automatic drive_idle();
        bus.lp_initdone   = 1'b1;
        bus.tx_c0_rdvalid = 1'b0;
        bus.tx_c1_wrvalid = 1'b0;
        bus.tx_c0_header  = '0;
        bus.tx_c1_header  = '0;
        bus.tx_c1_data    = '0;
    endtask

    task automatic rst_checks();
        chk("rst_c0_valid", bus.rx_c0_rdvalid, 0);
        chk("rst_c0_hdr", bus.rx_c0_header, 0);
        chk("rst_c0_data", bus.rx_c0_data, 0);
        chk("rst_c1_valid", bus.rx_c1_wrvalid, 0);
        chk("rst_c1_hdr", bus.rx_c1_header, 0);
        chk("rst_afull0", bus.tx_c0_almostfull, 0);
        chk("rst_afull1", bus.tx_c1_almostfull, 0);
        chk("rst_ovf", bus.ovf_err, 0);
        chk("rst_type", bus.type_err, 0);
    endtask

    // One cycle: check what the DUT shows now, then apply this cycle's request to the model and the bus.
    task automatic step(input bit init,
                        input bit v0, input logic [3:0] ty0, input logic [31:0] a0, input logic [13:0] m0,
                        input bit v1, input logic [3:0] ty1, input logic [31:0] a1, input logic [13:0] m1,
                        input logic [511:0] d1);
        rsp_t r;
        logic [RXW-1:0] eh;
        @(negedge clk);
        if (q0.size() > 0 && q0[0].due == t) begin
            chk("c0_valid", bus.rx_c0_rdvalid, 1);
            eh = '0;
            eh[`RX_MDATA_BITRANGE] = q0[0].mdata;
            chk("c0_hdr", bus.rx_c0_header, eh);
            chk("c0_data", bus.rx_c0_data, q0[0].data);
            void'(q0.pop_front());
        end else chk("c0_valid", bus.rx_c0_rdvalid, 0);
        if (q1.size() > 0 && q1[0].due == t) begin
            chk("c1_valid", bus.rx_c1_wrvalid, 1);
            eh = '0;
            eh[`RX_MDATA_BITRANGE] = q1[0].mdata;
            chk("c1_hdr", bus.rx_c1_header, eh);
            void'(q1.pop_front());
        end else chk("c1_valid", bus.rx_c1_wrvalid, 0);
        chk("c0_afull", bus.tx_c0_almostfull, in_flight(acc0, t - LAT + 1, t - 1) >= DEP - SLACK);
        chk("c1_afull", bus.tx_c1_almostfull, in_flight(acc1, t - LAT + 1, t - 1) >= DEP - SLACK);
        chk("ovf_err", bus.ovf_err, ovf_m);
        chk("type_err", bus.type_err, type_m);
        while (acc0.size() > 0 && acc0[0] < t - LAT) void'(acc0.pop_front());
        while (acc1.size() > 0 && acc1[0] < t - LAT) void'(acc1.pop_front());

        if (init && v0) begin
            if (!(ty0 inside {`ASE_TX0_RDLINE, `ASE_TX0_RDLINE_S, `ASE_TX0_RDLINE_I, `ASE_TX0_RDLINE_O}))
                type_m = 1'b1;
            else if (in_flight(acc0, t - LAT + 2, t - 1) < DEP) begin
                r.due = t + LAT; r.mdata = m0; r.data = mem_m[a0[IW-1:0]];
                q0.push_back(r);
                acc0.push_back(t);
            end else ovf_m = 1'b1;
        end
        if (init && v1) begin
            if (!(ty1 inside {`ASE_TX1_WRLINE, `ASE_TX1_WRTHRU, `ASE_TX1_WRFENCE}))
                type_m = 1'b1;
            else if (in_flight(acc1, t - LAT + 2, t - 1) < DEP) begin
                r.due = t + LAT; r.mdata = m1; r.data = '0;
                q1.push_back(r);
                acc1.push_back(t);
                if (ty1 != `ASE_TX1_WRFENCE) mem_m[a1[IW-1:0]] = d1;
            end else ovf_m = 1'b1;
        end

        bus.lp_initdone   = init;
        bus.tx_c0_rdvalid = v0;
        bus.tx_c0_header  = mkhdr(ty0, a0, m0);
        bus.tx_c1_wrvalid = v1;
        bus.tx_c1_header  = mkhdr(ty1, a1, m1);
        bus.tx_c1_data    = d1;
        t++;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, '0);
    endtask

    task automatic rd(input logic [3:0] ty, input logic [31:0] a, input logic [13:0] m);
        step(1, 1, ty, a, m, 0, 4'h0, 0, 0, '0);
    endtask

    task automatic wr(input logic [3:0] ty, input logic [31:0] a, input logic [13:0] m, input logic [511:0] d);
        step(1, 0, 4'h0, 0, 0, 1, ty, a, m, d);
    endtask

    task automatic pulse_reset(input int cycles);
        @(negedge clk);
        drive_idle();
        #1 sys_reset = 1'b1;
        #1 rst_checks();
        repeat (cycles) @(negedge clk);
        rst_checks();
        sys_reset = 1'b0;
        q0.delete(); q1.delete(); acc0.delete(); acc1.delete();
        ovf_m = 1'b0;
        type_m = 1'b0;
        t += cycles + 1;
    endtask

    initial begin
        errors = 0; checks = 0; t = 0; ovf_m = 0; type_m = 0;
        for (int i = 0; i < LINES; i++) mem_m[i] = '0;
        drive_idle();
        sys_reset = 1'b1;
        repeat (3) @(negedge clk);
        rst_checks();
        sys_reset = 1'b0;

        // Known line contents everywhere, paced so the write FIFO never fills.
        for (int i = 0; i < LINES; i++) begin
            wr(`ASE_TX1_WRLINE, i, 14'(i), '0);
            idle(2);
        end
        idle(LAT + 2);

        // Requests while lp_initdone is low are ignored, including bad types and writes.
        pat = {64{8'h3C}};
        step(0, 1, `ASE_TX0_RDLINE, 7, 14'h1, 1, `ASE_TX1_WRLINE, 7, 14'h2, pat);
        step(0, 1, 4'hF, 7, 14'h3, 1, 4'hF, 7, 14'h4, pat);
        idle(2);
        rd(`ASE_TX0_RDLINE, 7, 14'h5);
        idle(LAT + 2);

        // Single write then read of line 5.
        pat = {64{8'hA5}};
        wr(`ASE_TX1_WRLINE, 5, 14'h11, pat);
        idle(20);
        rd(`ASE_TX0_RDLINE, 5, 14'h12);
        idle(LAT + 2);

        // Back-to-back writes, mdata 0..9.
        for (int i = 0; i < 10; i++) wr(`ASE_TX1_WRLINE, 10 + i, 14'(i), rand_line());
        idle(LAT + 2);

        // Same-cycle read/write collision on line 3, then a read one cycle later.
        step(1, 1, `ASE_TX0_RDLINE, 3, 14'h21, 1, `ASE_TX1_WRLINE, 3, 14'h22, {512{1'b1}});
        rd(`ASE_TX0_RDLINE_I, 3, 14'h23);
        idle(LAT + 2);

        // Fence leaves memory alone; unknown ch1 type is dropped and flagged.
        wr(`ASE_TX1_WRFENCE, 5, 14'h7, rand_line());
        idle(2);
        rd(`ASE_TX0_RDLINE_O, 5, 14'h8);
        wr(4'hF, 6, 14'h9, rand_line());
        idle(LAT + 2);

        // Seventeen back-to-back reads against a 16-deep FIFO.
        for (int i = 0; i < 17; i++) rd(`ASE_TX0_RDLINE_S, i, 14'(100 + i));
        idle(LAT + 4);

        // Reset with reads in flight.
        for (int i = 0; i < 4; i++) rd(`ASE_TX0_RDLINE, 20 + i, 14'(200 + i));
        pulse_reset(3);
        idle(LAT + 4);

        // Random traffic on both channels.
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 19))
                0:       rty0 = 4'hF;
                1, 2:    rty0 = `ASE_TX0_RDLINE_S;
                3, 4:    rty0 = `ASE_TX0_RDLINE_I;
                5, 6:    rty0 = `ASE_TX0_RDLINE_O;
                default: rty0 = `ASE_TX0_RDLINE;
            endcase
            case ($urandom_range(0, 19))
                0:       rty1 = 4'hF;
                1, 2:    rty1 = `ASE_TX1_WRFENCE;
                3, 4, 5: rty1 = `ASE_TX1_WRTHRU;
                default: rty1 = `ASE_TX1_WRLINE;
            endcase
            rdat = rand_line();
            step($urandom_range(0, 19) != 0,
                 $urandom_range(0, 99) < 55, rty0, $urandom(), 14'($urandom()),
                 $urandom_range(0, 99) < 55, rty1, $urandom(), 14'($urandom()), rdat);
        end
        idle(LAT + 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
